// File: rtl/nibble_serial_adder.sv
// Multi-word adder that reuses one 4-bit ripple stage across NIB cycles.
// The operands shift right one nibble per cycle and the partial sum fills in from the top.
module nibble_serial_adder #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [4:0]       nib;
  logic             last;

  assign nib  = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= {nib[3:0], sum_sh[WIDTH-1:4]};
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          carry  <= nib[4];
          if (last) begin
            // Counter is cleared rather than wrapped so it never reaches NIB.
            cnt  <= '0;
            sum  <= {nib[3:0], sum_sh[WIDTH-1:4]};
            cout <= nib[4];
            ovf  <= a_sh[3] ^ b_sh[3] ^ nib[3] ^ nib[4];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one operation from IDLE (called #1 after a rising edge), scrambles
  // the operand inputs after the accept, waits for the result and completes the
  // output handshake after gap_out extra cycles. lat = -1 if no result appeared.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input int gap_out, output logic [15:0] s, output logic c,
                        output logic o, output int lat);
    int n;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ia; b = ib ^ 16'h5A5A; cin = ~ic;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) lat = n;
    end
    s = sum; c = cout; o = ovf;
    if (lat >= 0) begin
      repeat (gap_out) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({sum, cout, ovf} !== 18'h0) begin failures++; $display("FAIL reset_result got=%h/%b/%b exp=0000/0/0", sum, cout, ovf); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'hFFFF};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556, 16'hFFFF};
    logic        ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] s; logic c, o; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], 0, s, c, o, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat); end
      checks++; if (s !== es[i]) begin failures++; $display("FAIL vec%0d_sum got=%h exp=%h", i, s, es[i]); end
      checks++; if (c !== ec[i]) begin failures++; $display("FAIL vec%0d_cout got=%b exp=%b", i, c, ec[i]); end
      checks++; if (o !== eo[i]) begin failures++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, o, eo[i]); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_release got=%b/%b exp=0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_mid_change();
    int n;
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (sum !== 16'h5556 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL mid_change got=%h/%b/%b exp=5556/0/0", sum, cout, ovf); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; cin = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0 || ovf !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/5556/0/0", i, out_valid, sum, cout, ovf); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_flags%0d in_ready/busy got=%b/%b exp=0/1", i, in_ready, busy); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_handshake got=%b/%b/%b exp=0/1/0", out_valid, in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_accept busy/in_ready got=%b/%b exp=1/0", busy, in_ready); end
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 4) begin failures++; $display("FAIL bp_second_latency got=%0d exp=4", n); end
    checks++; if (sum !== 16'h0003 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL bp_second got=%h/%b/%b exp=0003/0/0", sum, cout, ovf); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] s; logic c, o; int lat;
    run_op(16'h8000, 16'h8001, 1'b0, 0, s, c, o, lat);
    checks++; if (s !== 16'h0001 || c !== 1'b1 || o !== 1'b1) begin
      failures++; $display("FAIL ar_pre got=%h/%b/%b exp=0001/1/1", s, c, o); end
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ar_flags got=%b/%b/%b exp=1/0/0", in_ready, out_valid, busy); end
    checks++; if ({sum, cout, ovf} !== 18'h0) begin
      failures++; $display("FAIL ar_result got=%h/%b/%b exp=0000/0/0", sum, cout, ovf); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL ar_release got=%b/%b exp=1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 1'b0, 0, s, c, o, lat);
    checks++; if (lat !== 4 || s !== 16'h0002 || c !== 1'b0 || o !== 1'b0) begin
      failures++; $display("FAIL ar_after got=%0d/%h/%b/%b exp=4/0002/0/0", lat, s, c, o); end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, s, es; logic rc, c, o, ec, eo; logic [16:0] full;
    int lat, results;
    results = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_op(ra, rb, rc, $urandom_range(0, 3), s, c, o, lat);
      full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      es = full[15:0];
      ec = full[16];
      eo = (ra[15] == rb[15]) && (es[15] != ra[15]);
      if (lat >= 0) results++;
      checks++; if (lat !== 4) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=4", i, lat); end
      checks++; if (s !== es || c !== ec || o !== eo) begin
        failures++; $display("FAIL rnd%0d_result a=%h b=%h cin=%b got=%h/%b/%b exp=%h/%b/%b", i, ra, rb, rc, s, c, o, es, ec, eo); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_duplicate out_valid got=%b exp=0", i, out_valid); end
    end
    checks++; if (results !== 1000) begin failures++; $display("FAIL rnd_count got=%0d exp=1000", results); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mid_change();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
